// File: rtl/io_pkg.sv
// Shared definitions for the I/O result UART transmitter.
package io_pkg;

   // Serialiser frame state
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } tx_state_e;

   // Core status word bit positions
   localparam int unsigned STAT_REQ    = 0;
   localparam int unsigned STAT_LEN_LO = 1;
   localparam int unsigned STAT_LEN_HI = 2;
   localparam int unsigned STAT_HALT   = 31;

   // UART frame shape (8N1)
   localparam int unsigned DATA_BITS = 8;
   localparam int unsigned STOP_BITS = 1;
   localparam int unsigned BIT_W     = $clog2(DATA_BITS);

   // Bytes-remaining counter holds 1..4
   localparam int unsigned BYTES_W = 3;

endpackage

// File: rtl/uart_tx_byte.sv
// Single-byte 8N1 serialiser; back-to-back bytes when start arrives on the last stop cycle.
module uart_tx_byte
   import io_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 868
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] byte_in,
   output logic       ready_c,
   output logic       done_c,
   output logic       txd
);

   localparam int unsigned TMR_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

   tx_state_e        state_q, state_d;
   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic [BIT_W-1:0] bit_q, bit_d;
   logic [7:0]       sh_q, sh_d;
   logic             txd_d;
   logic             tick_c;

   // State and datapath registers; reset drives the line idle-high at once
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         tmr_q   <= '0;
         bit_q   <= '0;
         sh_q    <= '0;
         txd     <= 1'b1;
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
         bit_q   <= bit_d;
         sh_q    <= sh_d;
         txd     <= txd_d;
      end
   end

   // Next-state, bit timing and line level
   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q + TMR_W'(1);
      bit_d   = bit_q;
      sh_d    = sh_q;
      txd_d   = 1'b1;
      tick_c  = (tmr_q == TMR_LAST);

      case (state_q)
         ST_IDLE: begin
            tmr_d = '0;
            if (start) begin
               state_d = ST_START;
               sh_d    = byte_in;
               bit_d   = '0;
            end
         end
         ST_START: begin
            if (tick_c) begin
               state_d = ST_DATA;
               tmr_d   = '0;
               bit_d   = '0;
            end
         end
         ST_DATA: begin
            if (tick_c) begin
               tmr_d = '0;
               sh_d  = {1'b0, sh_q[7:1]};
               if (bit_q == BIT_LAST) begin
                  state_d = ST_STOP;
               end else begin
                  bit_d = bit_q + BIT_W'(1);
               end
            end
         end
         ST_STOP: begin
            if (tick_c) begin
               tmr_d = '0;
               if (start) begin
                  state_d = ST_START;
                  sh_d    = byte_in;
                  bit_d   = '0;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      case (state_d)
         ST_START: txd_d = 1'b0;
         ST_DATA:  txd_d = sh_d[0];
         default:  txd_d = 1'b1;
      endcase

      done_c  = (state_q == ST_STOP) & tick_c;
      ready_c = (state_q == ST_IDLE) | done_c;
   end

endmodule

// File: rtl/io_result_uart_tx.sv
// Captures core result words on a send request and streams 1-4 bytes over UART.
module io_result_uart_tx
   import io_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 868,
   parameter int unsigned CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      status,
   input  logic [31:0]      result_bytes,
   output logic             uart_txd,
   output logic             busy,
   output logic             overrun,
   output logic             halted,
   output logic [CNT_W-1:0] tx_count
);

   logic               req_prev;
   logic               halt_prev;
   logic               halt_pend;
   logic [31:0]        shift_word;
   logic [BYTES_W-1:0] bytes_left;

   logic               req_edge_c;
   logic               halt_edge_c;
   logic               accept_c;
   logic               next_byte_c;
   logic               tx_start_c;
   logic [7:0]         tx_byte_c;
   logic               tx_ready_c;
   logic               tx_done_c;
   logic               unused_status;

   assign unused_status = ^status[STAT_HALT-1:STAT_LEN_HI+1];

   // Edge detection and byte sequencing decisions
   always_comb begin
      req_edge_c  = status[STAT_REQ] & ~req_prev;
      halt_edge_c = status[STAT_HALT] & ~halt_prev;
      accept_c    = req_edge_c & ~busy & ~halted & tx_ready_c;
      next_byte_c = busy & tx_done_c & (bytes_left > BYTES_W'(1));
      tx_start_c  = accept_c | next_byte_c;
      tx_byte_c   = accept_c ? result_bytes[7:0] : shift_word[15:8];
   end

   // Request capture, byte bookkeeping and sticky flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_prev   <= 1'b0;
         halt_prev  <= 1'b0;
         halt_pend  <= 1'b0;
         busy       <= 1'b0;
         overrun    <= 1'b0;
         halted     <= 1'b0;
         shift_word <= '0;
         bytes_left <= '0;
         tx_count   <= '0;
      end else begin
         req_prev  <= status[STAT_REQ];
         halt_prev <= status[STAT_HALT];

         if (halt_edge_c) begin
            halt_pend <= 1'b1;
         end
         // Halt waits for the transmitter to drain and for any same-cycle accept
         if (halt_pend & ~busy & ~accept_c) begin
            halted <= 1'b1;
         end
         if (req_edge_c & busy & ~halted) begin
            overrun <= 1'b1;
         end

         if (accept_c) begin
            shift_word <= result_bytes;
            bytes_left <= BYTES_W'(status[STAT_LEN_HI:STAT_LEN_LO]) + BYTES_W'(1);
            busy       <= 1'b1;
         end else if (busy & tx_done_c) begin
            tx_count   <= tx_count + CNT_W'(1);
            shift_word <= {8'h00, shift_word[31:8]};
            bytes_left <= bytes_left - BYTES_W'(1);
            if (bytes_left == BYTES_W'(1)) begin
               busy <= 1'b0;
            end
         end
      end
   end

   uart_tx_byte #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_tx (
      .clk     (clk),
      .rst     (rst),
      .start   (tx_start_c),
      .byte_in (tx_byte_c),
      .ready_c (tx_ready_c),
      .done_c  (tx_done_c),
      .txd     (uart_txd)
   );

endmodule

// File: tb/tb_io_result_uart_tx.sv
// Randomised self-checking bench for io_result_uart_tx against a frame-level reference model.
module tb_io_result_uart_tx;

   localparam int unsigned CPB   = 4;
   localparam int unsigned CNT_W = 16;

   logic             clk;
   logic             rst;
   logic [31:0]      status;
   logic [31:0]      result_bytes;
   logic             uart_txd;
   logic             busy;
   logic             overrun;
   logic             halted;
   logic [CNT_W-1:0] tx_count;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_count = 0;

   io_result_uart_tx #(
      .CLKS_PER_BIT(CPB),
      .CNT_W       (CNT_W)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .status       (status),
      .result_bytes (result_bytes),
      .uart_txd     (uart_txd),
      .busy         (busy),
      .overrun      (overrun),
      .halted       (halted),
      .tx_count     (tx_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Issue a request at a negedge and check the full serial waveform it must produce.
   // poke_at >= 0 re-raises the request mid-frame with different data.
   task automatic run_frame(input logic [31:0] word, input int len, input logic halt,
                            input int poke_at, input logic [31:0] poke_word);
      int            n;
      int            cyc;
      logic [7:0]    b;
      logic [9:0]    frame;
      logic [CPB-1:0] samp;
      logic          busy_ok;
      n = len + 1;
      status[31]    = halt;
      status[2:1]   = 2'(len);
      status[0]     = 1'b1;
      result_bytes  = word;
      cyc = 0;
      busy_ok = 1'b1;
      @(negedge clk);
      check("accept_latency_busy", 32'(busy), 32'd1);
      for (int i = 0; i < n; i++) begin
         b = 8'(word >> (8 * i));
         frame = {1'b1, b, 1'b0};
         for (int k = 0; k < 10; k++) begin
            for (int c = 0; c < int'(CPB); c++) begin
               samp[c] = uart_txd;
               if (busy !== 1'b1) busy_ok = 1'b0;
               if (poke_at >= 0 && cyc == poke_at) begin
                  status[0]    = 1'b0;
                  result_bytes = poke_word;
               end else if (poke_at >= 0 && cyc == poke_at + 1) begin
                  status[0] = 1'b1;
               end
               cyc++;
               @(negedge clk);
            end
            check($sformatf("txd_byte%0d_bit%0d", i, k), 32'(samp), 32'({CPB{frame[k]}}));
         end
      end
      check("busy_held_whole_frame", 32'(busy_ok), 32'd1);
      check("busy_falls_after_frame", 32'(busy), 32'd0);
      exp_count += n;
      check("tx_count", 32'(tx_count), 32'(exp_count % (1 << CNT_W)));
   endtask

   // Watch the line for a while and require it to stay idle
   task automatic expect_idle(input string tag, input int cycles);
      int active;
      active = 0;
      for (int c = 0; c < cycles; c++) begin
         if (uart_txd !== 1'b1 || busy !== 1'b0) active++;
         @(negedge clk);
      end
      check(tag, 32'(active), 32'd0);
   endtask

   task automatic drop_req(input int cycles);
      status[0] = 1'b0;
      repeat (cycles) @(negedge clk);
   endtask

   initial begin
      logic [31:0] w;
      int          l;
      rst          = 1'b1;
      status       = '0;
      result_bytes = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Reset state
      check("rst_txd", 32'(uart_txd), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_overrun", 32'(overrun), 32'd0);
      check("rst_halted", 32'(halted), 32'd0);
      check("rst_tx_count", 32'(tx_count), 32'd0);

      // Single byte 0xA5
      run_frame(32'h0000_00A5, 0, 1'b0, -1, '0);
      drop_req(2);

      // Four bytes back to back
      run_frame(32'h4433_2211, 3, 1'b0, -1, '0);
      drop_req(2);

      // Level held high sends once; a one-cycle low re-arms
      run_frame(32'h0000_005A, 0, 1'b0, -1, '0);
      expect_idle("held_level_no_resend", 500 - 10 * CPB);
      drop_req(1);
      run_frame(32'h0000_00C3, 0, 1'b0, -1, '0);
      check("held_overrun", 32'(overrun), 32'd0);
      drop_req(2);

      // Random words and lengths
      for (int t = 0; t < 8; t++) begin
         w = $urandom;
         l = int'($urandom_range(3, 0));
         run_frame(w, l, 1'b0, -1, '0);
         drop_req(int'($urandom_range(3, 1)));
      end
      check("rand_overrun", 32'(overrun), 32'd0);

      // Halt and request together: both bytes go out, then halted
      run_frame(32'h0000_BEEF, 1, 1'b1, -1, '0);
      check("halt_waits_drain", 32'(halted), 32'd0);
      @(negedge clk);
      check("halted_set", 32'(halted), 32'd1);
      drop_req(2);
      status[0] = 1'b1;
      result_bytes = $urandom;
      @(negedge clk);
      expect_idle("halted_ignores_req", 60);
      check("halted_no_overrun", 32'(overrun), 32'd0);
      check("halted_tx_count", 32'(tx_count), 32'(exp_count));

      // Asynchronous reset mid-frame
      rst = 1'b1;
      status = '0;
      @(negedge clk);
      rst = 1'b0;
      exp_count = 0;
      @(negedge clk);
      status[2:1]  = 2'd3;
      status[0]    = 1'b1;
      result_bytes = 32'hDEAD_BEEF;
      @(negedge clk);
      check("abort_started", 32'(busy), 32'd1);
      repeat (14) @(negedge clk);
      #1;
      rst    = 1'b1;
      status = '0;
      #1;
      check("abort_txd_async", 32'(uart_txd), 32'd1);
      check("abort_busy_async", 32'(busy), 32'd0);
      check("abort_tx_count", 32'(tx_count), 32'd0);
      check("abort_halted_cleared", 32'(halted), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      run_frame(32'h0000_0077, 0, 1'b0, -1, '0);
      drop_req(2);

      // Overrun: second edge ten cycles in is dropped
      run_frame(32'h0000_0039, 0, 1'b0, 10, 32'h0000_00C6);
      check("overrun_set", 32'(overrun), 32'd1);
      expect_idle("overrun_no_extra_byte", 40);
      check("overrun_tx_count", 32'(tx_count), 32'(exp_count));
      drop_req(2);
      check("overrun_sticky", 32'(overrun), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
